// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, 1-cycle synchronous imem requests, small {instr, pc} FIFO to decode.
// Optional MIPS branch-delay-slot preservation on redirect when FETCH_DELAY_SLOT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        w_clock,
    input  logic        w_reset_n,
    output logic [31:0] w_imem_addr_32,
    output logic        w_imem_rd_en,
    input  logic [31:0] w_imem_data_32,
    input  logic        w_stall,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc_32,
    output logic [31:0] w_instr_out_32,
    output logic [31:0] w_pc_out_32,
    output logic        w_instr_valid
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      pc_q;
    logic             inflight_q;
    logic [31:0]      inflight_pc_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [31:0] buf_instr [BUF_DEPTH];
    logic [31:0] buf_pc    [BUF_DEPTH];

    logic             valid;
    logic             pop;
    logic             push;
    logic             buf_we;
    logic             space;
    logic             issue;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      redirect_target;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_valid_q;
    logic [31:0] pend_pc_q;
    logic        slot_from_fetch;
`endif

    assign redirect_target = w_redirect_pc_32 & 32'hFFFF_FFFC;

    always_comb begin
        valid     = (count_q != '0);
        pop       = valid && !w_stall;
        push      = inflight_q;
        // Slots committed after this edge: buffered + returning - leaving.
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        space     = (occupancy < OCC_W'(BUF_DEPTH));
`ifdef FETCH_DELAY_SLOT_EN
        slot_from_fetch = (count_q == '0) && !inflight_q;
        if (w_redirect) begin
            issue  = w_reset_n && slot_from_fetch;
            buf_we = inflight_q && (count_q == '0);
        end else begin
            issue  = w_reset_n && space && !pend_valid_q;
            buf_we = push;
        end
`else
        issue  = w_reset_n && space && !w_redirect;
        buf_we = push && !w_redirect;
`endif
    end

    assign w_imem_rd_en   = issue;
    assign w_imem_addr_32 = pc_q;
    assign w_instr_valid  = valid;
    assign w_instr_out_32 = valid ? buf_instr[head_q] : 32'h0000_0000;
    assign w_pc_out_32    = valid ? buf_pc[head_q]    : 32'h0000_0000;

    // Storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge w_clock) begin
        if (w_reset_n && buf_we) begin
            buf_instr[tail_q] <= w_imem_data_32;
            buf_pc[tail_q]    <= inflight_pc_q;
        end
    end

    always_ff @(posedge w_clock) begin
        if (!w_reset_n) begin
            pc_q          <= PC_RESET;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= 32'h0000_0000;
`endif
        end else if (w_redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            // Keep exactly the oldest undelivered instruction as the delay slot.
            pend_valid_q <= 1'b1;
            pend_pc_q    <= redirect_target;
            if (count_q != '0) begin
                count_q    <= CNT_W'(1);
                tail_q     <= head_q + PTR_W'(1);
                inflight_q <= 1'b0;
            end else if (inflight_q) begin
                count_q    <= CNT_W'(1);
                tail_q     <= tail_q + PTR_W'(1);
                inflight_q <= 1'b0;
            end else begin
                inflight_q    <= issue;
                inflight_pc_q <= pc_q;
            end
`else
            pc_q       <= redirect_target;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
`endif
        end else begin
`ifdef FETCH_DELAY_SLOT_EN
            if (pend_valid_q) begin
                pc_q         <= pend_pc_q;
                pend_valid_q <= 1'b0;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
`else
            if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
`endif
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one depth-2 instance at PC 0 and one depth-4 instance
// starting at 0xFFFF_FFF8; each has its own word-indexed instruction memory model.
module tb_fetch_unit;

    logic        clk;
    int          checks;
    int          failures;

    logic        reset_n, stall, redirect;
    logic [31:0] redirect_pc, imem_data, addr, instr, pc_out;
    logic        rd_en, valid;

    logic        reset_n_b, stall_b, redirect_b;
    logic [31:0] redirect_pc_b, imem_data_b, addr_b, instr_b, pc_out_b;
    logic        rd_en_b, valid_b;

    fetch_unit #(.PC_RESET(32'h0000_0000), .BUF_DEPTH(2)) dut_a (
        .w_clock          (clk),
        .w_reset_n        (reset_n),
        .w_imem_addr_32   (addr),
        .w_imem_rd_en     (rd_en),
        .w_imem_data_32   (imem_data),
        .w_stall          (stall),
        .w_redirect       (redirect),
        .w_redirect_pc_32 (redirect_pc),
        .w_instr_out_32   (instr),
        .w_pc_out_32      (pc_out),
        .w_instr_valid    (valid)
    );

    fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_b (
        .w_clock          (clk),
        .w_reset_n        (reset_n_b),
        .w_imem_addr_32   (addr_b),
        .w_imem_rd_en     (rd_en_b),
        .w_imem_data_32   (imem_data_b),
        .w_stall          (stall_b),
        .w_redirect       (redirect_b),
        .w_redirect_pc_32 (redirect_pc_b),
        .w_instr_out_32   (instr_b),
        .w_pc_out_32      (pc_out_b),
        .w_instr_valid    (valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word[i] = i + 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'h0000_0100;
    endfunction

    always @(posedge clk) begin
        if (rd_en)   imem_data   <= mem_word(addr);
        if (rd_en_b) imem_data_b <= mem_word(addr_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] exp_pc);
        check({tag, "_valid"}, {31'd0, v}, 32'd1);
        check({tag, "_instr"}, ins, mem_word(exp_pc));
        check({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        logic [31:0] exp_pc;
        checks = 0;
        failures = 0;
        imem_data = '0;
        imem_data_b = '0;
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        reset_n_b = 1'b0; stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = '0;
        tick();
        tick();

        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_addr", addr, 32'h0);

        // Stream from reset: first valid two cycles after the first issue.
        reset_n = 1'b1;
        #1;
        check("t1_first_rd_en", {31'd0, rd_en}, 32'd1);
        check("t1_first_addr", addr, 32'h0);
        tick();
        check("t1_not_yet_valid", {31'd0, valid}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_pair("t1_stream", valid, instr, pc_out, 32'(4 * k));
            if (k < 3) tick();
        end

        // Stall with one buffered and one in flight: fetch stops, output frozen.
        stall = 1'b1;
        #1;
        check("t2_rd_en_full", {31'd0, rd_en}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_pair("t2_hold", valid, instr, pc_out, 32'h0000_000C);
            check("t2_hold_rd_en", {31'd0, rd_en}, 32'd0);
        end
        stall = 1'b0;
        #1;
        check("t2_release_rd_en", {31'd0, rd_en}, 32'd1);
        exp_pc = 32'h0000_0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_pair("t2_resume", valid, instr, pc_out, exp_pc);
            exp_pc += 32'd4;
        end

        // Redirect with stall and a push in the same cycle; low target bits ignored.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        #1;
        check("t4_redir_rd_en", {31'd0, rd_en}, 32'd0);
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        #1;
        check("t4_empty_valid", {31'd0, valid}, 32'd0);
        check("t4_empty_instr", instr, 32'h0);
        check("t4_restart_rd_en", {31'd0, rd_en}, 32'd1);
        check("t4_restart_addr", addr, 32'h0000_0040);
        tick();
        check("t4_latency_valid", {31'd0, valid}, 32'd0);
        tick();
        check_pair("t4_target", valid, instr, pc_out, 32'h0000_0040);
        tick();
        check_pair("t4_next", valid, instr, pc_out, 32'h0000_0044);
        tick();
        check_pair("t4_next2", valid, instr, pc_out, 32'h0000_0048);

        // Mid-stream reset with two buffered entries.
        stall = 1'b1;
        tick();
        check_pair("t6_full", valid, instr, pc_out, 32'h0000_0048);
        check("t6_full_rd_en", {31'd0, rd_en}, 32'd0);
        reset_n = 1'b0;
        tick();
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_instr", instr, 32'h0);
        check("t6_rst_pc_out", pc_out, 32'h0);
        check("t6_rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("t6_rst_addr", addr, 32'h0);
        reset_n = 1'b1;
        stall = 1'b0;
        #1;
        check("t6_restart_rd_en", {31'd0, rd_en}, 32'd1);
        tick();
        tick();
        check_pair("t6_restart", valid, instr, pc_out, 32'h0000_0000);

        // PC wrap from 0xFFFF_FFF8 on the depth-4 instance.
        reset_n_b = 1'b1;
        #1;
        check("t5_first_rd_en", {31'd0, rd_en_b}, 32'd1);
        check("t5_first_addr", addr_b, 32'hFFFF_FFF8);
        tick();
        tick();
        check_pair("t5_pc0", valid_b, instr_b, pc_out_b, 32'hFFFF_FFF8);
        tick();
        check_pair("t5_pc1", valid_b, instr_b, pc_out_b, 32'hFFFF_FFFC);
        tick();
        check_pair("t5_pc2", valid_b, instr_b, pc_out_b, 32'h0000_0000);

        // Redirect with two buffered and one in flight: nothing stale survives.
        stall_b = 1'b1;
        #1;
        check("t3_stall_rd_en", {31'd0, rd_en_b}, 32'd1);
        tick();
        check_pair("t3_before", valid_b, instr_b, pc_out_b, 32'h0000_0000);
        stall_b = 1'b0;
        redirect_b = 1'b1;
        redirect_pc_b = 32'h0000_0040;
        #1;
        check("t3_redir_rd_en", {31'd0, rd_en_b}, 32'd0);
        tick();
        redirect_b = 1'b0;
        #1;
        check("t3_flush_valid", {31'd0, valid_b}, 32'd0);
        check("t3_restart_addr", addr_b, 32'h0000_0040);
        check("t3_restart_rd_en", {31'd0, rd_en_b}, 32'd1);
        tick();
        check("t3_latency_valid", {31'd0, valid_b}, 32'd0);
        tick();
        check_pair("t3_target", valid_b, instr_b, pc_out_b, 32'h0000_0040);
        tick();
        check_pair("t3_next", valid_b, instr_b, pc_out_b, 32'h0000_0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the instruction decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a small FIFO and presents one instruction per cycle, with its PC, to decode.
- Honours a decode-side stall and a branch/jump redirect from execute.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word aligned.
BUF_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
w_clock  input  1  clock; all state updates on rising edge.
w_reset_n  input  1  reset; synchronous, active-low.
w_imem_addr_32  output  32  byte address of read request; bits [1:0] always 0.
w_imem_rd_en  output  1  read request strobe; the word returns on w_imem_data_32 on the following cycle.
w_imem_data_32  input  32  read data, valid exactly 1 cycle after w_imem_rd_en.
w_stall  input  1  decode cannot accept; hold the output instruction.
w_redirect  input  1  single-cycle pulse; the PC must change to w_redirect_pc_32.
w_redirect_pc_32  input  32  redirect target; bits [1:0] ignored (treated as 0).
w_instr_out_32  output  32  instruction to decoder; 32'h0000_0000 (sll nop) when not valid.
w_pc_out_32  output  32  PC of w_instr_out_32.
w_instr_valid  output  1  w_instr_out_32/w_pc_out_32 are meaningful.

Behaviour:
- Reset (w_reset_n=0 at a rising edge): PC=PC_RESET; buffer empty; in-flight flag clear.
  - Outputs after reset: w_imem_rd_en=0, w_instr_valid=0, w_instr_out_32=0, w_pc_out_32=0, w_imem_addr_32=PC_RESET.
  - Reset asserted mid-operation discards all buffered and in-flight words.
- State:
  - pc_q: next address to fetch.
  - inflight_q (1 bit) plus inflight_pc_q.
  - FIFO of {instr, pc} with head/tail pointers and a count wrapping at BUF_DEPTH.
- Issue (combinational): w_imem_rd_en = reset released AND (count + inflight_q + [pop this cycle ? -1 : 0]) < BUF_DEPTH AND NOT w_redirect.
  - w_imem_addr_32 = pc_q.
  - On issue: pc_q += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); inflight_q=1 with inflight_pc_q=pc_q; otherwise inflight_q=0.
- Return: when inflight_q=1, push {w_imem_data_32, inflight_pc_q} into the FIFO. Space is guaranteed by the issue rule; overflow is impossible by construction.
- Output: head entry drives w_instr_out_32/w_pc_out_32; w_instr_valid = count != 0.
  - Pop when w_instr_valid AND NOT w_stall.
  - Push and pop in the same cycle leaves count unchanged.
  - Empty FIFO with a return in flight: the word is first visible one cycle after return; no bypass.
- Latency: the first instruction after reset release is visible 2 cycles after the first issue. Steady-state throughput is 1 instruction/cycle with no stall.
- Stall: outputs hold stable while w_stall=1. Fetch stops when the buffer is full. No word is dropped or duplicated.
- Redirect (without macro): in the cycle w_redirect=1:
  - FIFO cleared; any in-flight return squashed (not pushed).
  - pc_q = {w_redirect_pc_32[31:2],2'b00}; no issue that cycle; w_instr_valid=0 the next cycle.
  - Redirect has priority over stall, pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.

Optional Feature:
FETCH_DELAY_SLOT_EN
- Defined: MIPS branch-delay slot preserved. On redirect, exactly one instruction is kept: the oldest undelivered one.
  - Source priority: FIFO head if count>0; else the in-flight word; else one fetch of the current pc_q, issued immediately.
  - All other entries are squashed.
  - pc_q is loaded with the target only after the delay-slot fetch has been issued.
  - A pending-redirect register holds the target until then.
- Undefined: redirect squashes everything as described in Behaviour; no pending-redirect register exists.

Test Plan:
1. Reset release, PC_RESET=0, memory word[i]=i+0x100, w_stall=0 -> valid pairs (0x100,0x0),(0x101,0x4),(0x102,0x8)... one per cycle; first valid 2 cycles after first rd_en.
2. Hold w_stall=1 for 5 cycles while streaming -> output frozen; w_imem_rd_en drops once 2 entries are buffered; on release the sequence resumes with no gap, drop or duplicate.
3. w_redirect=1 with w_redirect_pc_32=0x40 while FIFO holds 2 entries and 1 is in flight -> next valid output is (mem[0x40],0x40); no stale PC appears; with FETCH_DELAY_SLOT_EN, FIFO head appears first, then 0x40.
4. Redirect on the same cycle as w_stall=1 and a push -> redirect wins; FIFO empty next cycle; fetch restarts at the target.
5. PC_RESET=32'hFFFF_FFF8 -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 delivered in order.
6. w_reset_n=0 for 1 cycle mid-stream with 2 buffered -> w_instr_valid=0, w_instr_out_32=0 next cycle; fetch restarts at PC_RESET.
